mem_dump_streamer: RTL
======================

// Module: mem_dump_streamer
// PURPOSE
//  Synthesizable readback engine for the banked data memory of the filter core. The memory is NUM_LANES byte-lane
//  banks, and lane L holds byte index 4*w+L of word w.
//  On a start pulse the block walks a byte range word by word. It reads all lanes of each word in one access and
//  streams (byte index, byte value) beats over valid/ready, in ascending byte order.
//  It replaces simulation-only hierarchical memory dumps. It feeds a UART or debug host, and its done flag drives a LED.
// PARAMETERS
//  NUM_LANES    4   byte-lane banks per word; power of two, >=1
//  DATA_W       8   bits per lane
//  WORD_ADDR_W  10  word address width of each bank
//  IDX_W        WORD_ADDR_W+$clog2(NUM_LANES)  byte index width (localparam)
//  CSUM_W       16  checksum width (used only with DUMP_CHECKSUM_EN)
// PORTS
//  clk          in   1                   system clock
//  rst          in   1                   asynchronous, active-low reset
//  start        in   1                   1-cycle start request; ignored while busy
//  abort        in   1                   synchronous cancel
//  base_idx     in   IDX_W               first byte index, sampled on accepted start
//  byte_cnt     in   IDX_W+1             number of bytes to emit, sampled on accepted start
//  mem_addr     out  WORD_ADDR_W         shared word address to all banks
//  mem_re       out  1                   read enable
//  mem_rdata    in   NUM_LANES*DATA_W    lane L occupies bits [L*DATA_W +: DATA_W]; 1-cycle synchronous read
//  out_valid    out  1                   beat valid
//  out_ready    in   1                   sink accepts beat
//  out_idx      out  IDX_W               byte index of beat
//  out_data     out  DATA_W              byte value
//  out_last     out  1                   final beat of dump
//  busy         out  1                   dump in progress
//  done         out  1                   1-cycle pulse after the final beat is accepted
// BEHAVIOUR
//  Reset values: all outputs 0; FSM IDLE. Reset mid-dump drops the beat in flight.
//  FSM states:
//   IDLE: on start with byte_cnt==0, pulse done next cycle and emit no beats. Otherwise go to RD, busy=1.
//   RD: mem_re=1 for one cycle with mem_addr=cur_idx>>log2(NUM_LANES); go to CAP.
//   CAP: latch mem_rdata into the word register; go to EMIT.
//   EMIT: present lane cur_idx[log2(NUM_LANES)-1:0]. Advance only on out_valid&&out_ready.
//    After the beat with remaining==1, go to DONE (or CSUM when the macro is defined).
//    Otherwise, when the lane wraps to 0, go to RD.
//   DONE: done=1, busy=0 for one cycle; go to IDLE.
//  Unaligned base: the first word skips lanes below the base lane. The last word stops mid-word.
//  No bank is read twice per word.
//  Latency: the first beat is valid 3 cycles after start. A full word costs 2 + NUM_LANES cycles at ready=1.
//  Handshake: out_valid/idx/data/last stay stable until accepted, and valid never drops without acceptance.
//  Index wrap: cur_idx wraps modulo 2^IDX_W. mem_addr wraps accordingly and no error is flagged.
//  abort: takes priority in any state. Next cycle the FSM is IDLE, with out_valid=0 and busy=0. No done pulse.
//  start in the same cycle as the abort is ignored.
//  start while busy is ignored; the latched base/count are unaffected.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//   Adds output ports out_is_csum (1) and out_csum (CSUM_W).
//   A running sum of emitted bytes, modulo 2^CSUM_W, is cleared on start.
//   After the last data beat, CSUM state emits one extra beat: out_is_csum=1, out_csum=sum, out_data=sum[DATA_W-1:0],
//   out_idx=0, out_last=1.
//   The data beat before it has out_last=0. byte_cnt==0 emits no checksum beat.
//  DUMP_CHECKSUM_EN undefined: no CSUM state and no extra ports; out_last is on the final data beat.
// STRUCTURE
//  Shared package dump_pkg holds the FSM state enum (IDLE, RD, CAP, EMIT, CSUM, DONE) and the lane-select helper
//  function.
//  One sub-module, dump_lane_mux: it selects lane cur_idx[log2(NUM_LANES)-1:0] from the latched word.
//  Counters and the FSM stay in the top level.
// TESTING
//  1 Aligned dump: banks preloaded with byte k = k mod 256; base=0, cnt=8, ready=1.
//    Expect beats idx 0..7 with data 0..7, last on idx 7, done 1 cycle later, and exactly 2 mem_re pulses.
//  2 Unaligned: base=5, cnt=6.
//    Expect idx 5..10, mem_addr sequence 1,2, and lanes 0 of word 1 and 3 of word 2 never emitted.
//  3 Backpressure: ready toggles 1-0-0-1 randomly during cnt=12.
//    Expect idx/data stable while valid&&!ready, no beat lost or duplicated, and all 12 in order.
//  4 Boundaries:
//    - cnt=0: done pulse, no beats.
//    - base=2^IDX_W-2, cnt=4: idx FFE,FFF,000,001 for WORD_ADDR_W=10.
//    - Start while busy is ignored.
//  5 Abort/reset: abort after 3 accepted beats of cnt=16 -> next cycle valid=0, busy=0, no done.
//    rst low mid-EMIT -> all outputs 0 immediately. A fresh start then works normally.
//  6 DUMP_CHECKSUM_EN: bytes 1..10, base=0, cnt=10.
//    Expect 10 data beats with last=0, then a checksum beat with out_csum=55, is_csum=1, last=1.
//    Rerun without the macro: last on the 10th beat.

Source files
------------

// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared FSM state type and lane-select helper for the memory dump streamer
//
// Contents:
//   dump_state_t : FSM states IDLE, RD, CAP, EMIT, CSUM, DONE
//   lane_of()    : byte index -> lane number within a word
package dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_EMIT = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5
    } dump_state_t;

    // Lane counts are powers of two, so the lane is the low bits of the byte index.
    function automatic int unsigned lane_of(input logic [31:0] idx, input int unsigned lanes);
        return idx & (lanes - 1);
    endfunction

endpackage

// File: rtl/dump_lane_mux.sv
// rtl/dump_lane_mux.sv - selects one byte lane out of a latched memory word
//
// Ports:
//   word  in   NUM_LANES*DATA_W  latched word, lane L at [L*DATA_W +: DATA_W]
//   sel   in   SEL_W             lane to present
//   data  out  DATA_W            selected lane value
module dump_lane_mux
    import dump_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int SEL_W     = 2
) (
    input  logic [NUM_LANES*DATA_W-1:0] word,
    input  logic [SEL_W-1:0]            sel,
    output logic [DATA_W-1:0]           data
);

    always_comb begin
        data = word[DATA_W-1:0];
        for (int l = 1; l < NUM_LANES; l++) begin
            if (sel == SEL_W'(l)) begin
                data = word[l*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mem_dump_streamer.sv
// rtl/mem_dump_streamer.sv - walks a byte range of the banked data memory and streams (index, byte) beats
//
// Optional feature macro: DUMP_CHECKSUM_EN (adds a trailing checksum beat and the out_is_csum/out_csum ports).
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start, abort       1-cycle start request (ignored while busy), synchronous cancel
//   base_idx, byte_cnt first byte index and byte count, sampled on accepted start
//   mem_addr, mem_re   shared word address and read enable to all lane banks
//   mem_rdata          all lanes of the addressed word, one cycle after mem_re
//   out_valid/ready    beat handshake; out_idx, out_data, out_last describe the beat
//   busy, done         dump in progress; 1-cycle pulse after the final beat is accepted
//   out_is_csum, out_csum  (DUMP_CHECKSUM_EN only) checksum beat marker and value
module mem_dump_streamer
    import dump_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int DATA_W      = 8,
    parameter int WORD_ADDR_W = 10,
`ifdef DUMP_CHECKSUM_EN
    parameter int CSUM_W      = 16,
`endif
    localparam int LANE_BITS  = $clog2(NUM_LANES),
    localparam int IDX_W      = WORD_ADDR_W + LANE_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [IDX_W-1:0]            base_idx,
    input  logic [IDX_W:0]              byte_cnt,
    output logic [WORD_ADDR_W-1:0]      mem_addr,
    output logic                        mem_re,
    input  logic [NUM_LANES*DATA_W-1:0] mem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
`ifdef DUMP_CHECKSUM_EN
    output logic                        out_is_csum,
    output logic [CSUM_W-1:0]           out_csum,
`endif
    output logic                        busy,
    output logic                        done
);

    // A single-lane memory still needs a 1-bit select vector.
    localparam int LSEL_W = (LANE_BITS > 0) ? LANE_BITS : 1;

    dump_state_t                 state;
    logic [IDX_W-1:0]            cur_idx;
    logic [IDX_W:0]              remaining;
    logic [NUM_LANES*DATA_W-1:0] word_q;
    logic [LSEL_W-1:0]           lane;
    logic [DATA_W-1:0]           lane_data;
    logic                        last_lane;
    logic                        final_beat;
`ifdef DUMP_CHECKSUM_EN
    logic [CSUM_W-1:0]           csum;
`endif

    assign lane       = LSEL_W'(lane_of(32'(cur_idx), NUM_LANES));
    assign last_lane  = (lane == LSEL_W'(NUM_LANES - 1));
    assign final_beat = (remaining == (IDX_W+1)'(1));

    dump_lane_mux #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .SEL_W     (LSEL_W)
    ) u_lane_mux (
        .word (word_q),
        .sel  (lane),
        .data (lane_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cur_idx   <= '0;
            remaining <= '0;
            word_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_idx   <= base_idx;
                        remaining <= byte_cnt;
`ifdef DUMP_CHECKSUM_EN
                        csum      <= '0;
`endif
                        state     <= (byte_cnt == '0) ? ST_DONE : ST_RD;
                    end
                end
                ST_RD: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    // One read covers every lane of the word; lanes are served from here.
                    word_q <= mem_rdata;
                    state  <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        cur_idx   <= cur_idx + IDX_W'(1);
                        remaining <= remaining - (IDX_W+1)'(1);
`ifdef DUMP_CHECKSUM_EN
                        csum      <= csum + CSUM_W'(lane_data);
`endif
                        if (final_beat) begin
`ifdef DUMP_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
`endif
                        end else if (last_lane) begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_CSUM: begin
                    if (out_ready) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the state so that reset and abort clear them immediately.
    always_comb begin
        mem_re    = (state == ST_RD);
        mem_addr  = mem_re ? WORD_ADDR_W'(cur_idx >> LANE_BITS) : '0;
        busy      = (state == ST_RD) || (state == ST_CAP) || (state == ST_EMIT) || (state == ST_CSUM);
        done      = (state == ST_DONE);
        out_valid = (state == ST_EMIT);
        out_idx   = (state == ST_EMIT) ? cur_idx : '0;
        out_data  = (state == ST_EMIT) ? lane_data : '0;
`ifdef DUMP_CHECKSUM_EN
        out_last    = (state == ST_CSUM);
        out_is_csum = (state == ST_CSUM);
        out_csum    = (state == ST_CSUM) ? csum : '0;
        if (state == ST_CSUM) begin
            out_valid = 1'b1;
            out_data  = DATA_W'(csum);
        end
`else
        out_last  = (state == ST_EMIT) && final_beat;
`endif
    end

endmodule
